// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : time_pkg
//  Purpose  : Shared types, limits and helpers for the time-of-day counter.
//             bcd2_t holds two BCD digits {tens, units}.
//  Revision : 1.0  initial release
// ============================================================================
package time_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Both digits must be decimal digits, and the value must not exceed max.
  // Once both digits are known to be <= 9, an ordinary binary compare
  // orders BCD values correctly.
  function automatic logic bcd2_valid(bcd2_t v, bcd2_t max);
    logic digits_ok;
    digits_ok  = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    bcd2_valid = digits_ok && (v <= max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2_counter
//  Purpose  : Two-digit BCD counter that counts 00..MAX and wraps to 00.
//             A load overrides counting. carry flags the wrap so the next
//             stage of a cascade can advance in the same cycle.
//  Ports    : CLK      in   clock, rising edge
//             RST      in   synchronous active-high reset (q -> 00)
//             inc      in   advance by one this cycle
//             load     in   take load_val this cycle (priority over inc)
//             load_val in   BCD value to load
//             q        out  current BCD value (registered)
//             carry    out  combinational: inc && q == MAX
//  Revision : 1.0  initial release
// ============================================================================
module bcd2_counter
  import time_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t q,
  output logic  carry
);

  bcd2_t r_q;

  assign q     = r_q;
  assign carry = inc && (r_q == MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 8'h00;
    end else if (load) begin
      r_q <= load_val;
    end else if (inc) begin
      if (r_q == MAX) begin
        r_q <= 8'h00;
      end else if (r_q[3:0] == 4'd9) begin
        // Decimal carry from units to tens keeps both digits valid BCD.
        r_q <= {r_q[7:4] + 4'd1, 4'd0};
      end else begin
        r_q <= {r_q[7:4], r_q[3:0] + 4'd1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : time_counter
//  Purpose  : 24-hour BCD time-of-day counter. Divides CLK down to a
//             one-second tick and cascades seconds -> minutes -> hours.
//             Supports a validated one-cycle load strobe.
//  Ports    : CLK       in   clock, rising edge
//             RST       in   synchronous active-high reset
//             EN        in   count enable (0 freezes prescaler and time)
//             LOAD      in   one-cycle load strobe
//             LOAD_HH   in   BCD hours to load
//             LOAD_MM   in   BCD minutes to load
//             LOAD_SS   in   BCD seconds to load
//             HH/MM/SS  out  current time, BCD
//             SEC_TICK  out  pulse with each new SS value
//             DAY_WRAP  out  pulse when 23:59:59 rolls over to 00:00:00
//             LOAD_ERR  out  pulse after a rejected LOAD
//  Revision : 1.0  initial release
// ============================================================================
module time_counter
  import time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  EN,
  input  logic  LOAD,
  input  bcd2_t LOAD_HH,
  input  bcd2_t LOAD_MM,
  input  bcd2_t LOAD_SS,
  output bcd2_t HH,
  output bcd2_t MM,
  output bcd2_t SS,
  output logic  SEC_TICK,
  output logic  DAY_WRAP,
  output logic  LOAD_ERR
);

  localparam int            PW      = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic          r_day_wrap;
  logic          r_load_err;

  logic w_load_fields_ok;
  logic w_load_ok;
  logic w_load_bad;
  logic w_tick;
  logic w_ss_carry;
  logic w_mm_carry;
  logic w_hh_carry;

  assign w_load_fields_ok = bcd2_valid(LOAD_HH, HOUR_MAX) &&
                            bcd2_valid(LOAD_MM, MIN_MAX)  &&
                            bcd2_valid(LOAD_SS, SEC_MAX);
  assign w_load_ok  = LOAD &&  w_load_fields_ok;
  assign w_load_bad = LOAD && !w_load_fields_ok;

  // A valid load suppresses the advance on the same edge; a rejected load
  // is ignored, so the tick still fires.
  assign w_tick = EN && (r_presc == PS_LAST) && !w_load_ok;

  // Prescaler: a valid load restarts the second so the first tick after it
  // lands a full TICKS_PER_SEC enabled cycles later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
    end else if (w_load_ok) begin
      r_presc <= '0;
    end else if (EN) begin
      if (r_presc == PS_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  bcd2_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_tick),
    .load     (w_load_ok),
    .load_val (LOAD_SS),
    .q        (SS),
    .carry    (w_ss_carry)
  );

  bcd2_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_ss_carry),
    .load     (w_load_ok),
    .load_val (LOAD_MM),
    .q        (MM),
    .carry    (w_mm_carry)
  );

  bcd2_counter #(
    .MAX (HOUR_MAX)
  ) u_hour (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_mm_carry),
    .load     (w_load_ok),
    .load_val (LOAD_HH),
    .q        (HH),
    .carry    (w_hh_carry)
  );

  // Pulses are registered alongside the counters so each one is high in the
  // same cycle as the time value it describes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_day_wrap <= w_hh_carry;
      r_load_err <= w_load_bad;
    end
  end

  assign SEC_TICK = r_sec_tick;
  assign DAY_WRAP = r_day_wrap;
  assign LOAD_ERR = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_counter
//  Purpose  : Directed self-checking bench for time_counter with
//             TICKS_PER_SEC = 4. Expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_counter;

  localparam int TPS = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_HH = 8'h00;
  logic [7:0] LOAD_MM = 8'h00;
  logic [7:0] LOAD_SS = 8'h00;
  logic [7:0] HH, MM, SS;
  logic       SEC_TICK, DAY_WRAP, LOAD_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  time_counter #(
    .TICKS_PER_SEC (TPS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .LOAD     (LOAD),
    .LOAD_HH  (LOAD_HH),
    .LOAD_MM  (LOAD_MM),
    .LOAD_SS  (LOAD_SS),
    .HH       (HH),
    .MM       (MM),
    .SS       (SS),
    .SEC_TICK (SEC_TICK),
    .DAY_WRAP (DAY_WRAP),
    .LOAD_ERR (LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    check({tag, "_hh"}, {24'd0, HH}, {24'd0, h});
    check({tag, "_mm"}, {24'd0, MM}, {24'd0, m});
    check({tag, "_ss"}, {24'd0, SS}, {24'd0, s});
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    LOAD = 1'b1; LOAD_HH = h; LOAD_MM = m; LOAD_SS = s;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    // ---------------- reset then count ----------------
    RST = 1'b1; EN = 1'b0;
    step(); step();
    check_time("rst", 8'h00, 8'h00, 8'h00);
    check("rst_tick", {31'd0, SEC_TICK}, 32'd0);
    check("rst_wrap", {31'd0, DAY_WRAP}, 32'd0);
    check("rst_err",  {31'd0, LOAD_ERR}, 32'd0);
    RST = 1'b0; EN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("cnt_tick_%0d", i), {31'd0, SEC_TICK}, (i % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cnt_ss_%0d", i), {24'd0, SS}, i / 4);
    end

    // ---------------- midnight wrap ----------------
    do_load(8'h23, 8'h59, 8'h58);
    check_time("mid_load", 8'h23, 8'h59, 8'h58);
    check("mid_load_tick", {31'd0, SEC_TICK}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("mid_tick_%0d", i), {31'd0, SEC_TICK}, (i % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("mid_wrap_%0d", i), {31'd0, DAY_WRAP}, (i == 8) ? 32'd1 : 32'd0);
      if (i == 4) check_time("mid_59", 8'h23, 8'h59, 8'h59);
    end
    check_time("mid_00", 8'h00, 8'h00, 8'h00);
    step();
    check("mid_wrap_after", {31'd0, DAY_WRAP}, 32'd0);
    check("mid_tick_after", {31'd0, SEC_TICK}, 32'd0);

    // ---------------- minute carry and BCD ----------------
    do_load(8'h12, 8'h09, 8'h59);
    check_time("bcd_load", 8'h12, 8'h09, 8'h59);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("bcd_mm_units_%0d", i), {31'd0, MM[3:0] <= 4'd9}, 32'd1);
      check($sformatf("bcd_ss_units_%0d", i), {31'd0, SS[3:0] <= 4'd9}, 32'd1);
    end
    check_time("bcd_carry", 8'h12, 8'h10, 8'h00);
    check("bcd_tick", {31'd0, SEC_TICK}, 32'd1);

    // ---------------- invalid loads ----------------
    step();                                   // prescaler 1
    do_load(8'h05, 8'h60, 8'h00);             // prescaler 2
    check("inv_mm_err", {31'd0, LOAD_ERR}, 32'd1);
    check_time("inv_mm", 8'h12, 8'h10, 8'h00);
    step();                                   // prescaler 3
    check("inv_mm_err_clr", {31'd0, LOAD_ERR}, 32'd0);
    check("inv_mm_no_tick", {31'd0, SEC_TICK}, 32'd0);
    step();                                   // tick
    check("inv_mm_tick", {31'd0, SEC_TICK}, 32'd1);
    check_time("inv_mm_next", 8'h12, 8'h10, 8'h01);
    step(); step(); step();                   // prescaler 3
    do_load(8'h01, 8'h02, 8'h3A);             // rejected load on the tick edge
    check("inv_ss_err", {31'd0, LOAD_ERR}, 32'd1);
    check("inv_ss_tick", {31'd0, SEC_TICK}, 32'd1);
    check_time("inv_ss", 8'h12, 8'h10, 8'h02);
    do_load(8'h24, 8'h00, 8'h00);             // prescaler 1
    check("inv_hh_err", {31'd0, LOAD_ERR}, 32'd1);
    check_time("inv_hh", 8'h12, 8'h10, 8'h02);

    // ---------------- pause ----------------
    step();                                   // prescaler 2
    EN = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("pause_tick_%0d", i), {31'd0, SEC_TICK}, 32'd0);
    end
    check_time("pause", 8'h12, 8'h10, 8'h02);
    EN = 1'b1;
    step();
    check("resume_no_tick", {31'd0, SEC_TICK}, 32'd0);
    step();
    check("resume_tick", {31'd0, SEC_TICK}, 32'd1);
    check_time("resume", 8'h12, 8'h10, 8'h03);

    // ---------------- valid load on the tick edge ----------------
    step(); step(); step();                   // prescaler 3
    do_load(8'h07, 8'h30, 8'h15);
    check_time("ld_tick", 8'h07, 8'h30, 8'h15);
    check("ld_tick_pulse", {31'd0, SEC_TICK}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("ld_next_tick_%0d", i), {31'd0, SEC_TICK}, (i == 4) ? 32'd1 : 32'd0);
    end
    check_time("ld_next", 8'h07, 8'h30, 8'h16);

    // ---------------- load while disabled, then reset mid-second ----------------
    EN = 1'b0;
    do_load(8'h10, 8'h20, 8'h30);
    check_time("ld_dis", 8'h10, 8'h20, 8'h30);
    EN = 1'b1;
    step(); step();                           // prescaler 2
    RST = 1'b1;
    step();
    check_time("rst_mid", 8'h00, 8'h00, 8'h00);
    check("rst_mid_tick", {31'd0, SEC_TICK}, 32'd0);
    check("rst_mid_wrap", {31'd0, DAY_WRAP}, 32'd0);
    check("rst_mid_err",  {31'd0, LOAD_ERR}, 32'd0);
    RST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("rst_mid_first_%0d", i), {31'd0, SEC_TICK}, (i == 4) ? 32'd1 : 32'd0);
    end
    check_time("rst_mid_after", 8'h00, 8'h00, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
